// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: packs right-aligned, MSB-first variable-length codes into a byte stream, 1-padding on flush.
// Define JPEG_BYTE_STUFF_EN to insert a 0x00 byte after every emitted 0xFF.
module jpeg_bit_packer #(
    parameter int CODE_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CODE_W-1:0]            in_code,
    input  logic [$clog2(CODE_W+1)-1:0]  in_len,
    input  logic                         in_flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic                         flush_done
);
    localparam int ACC_W = 2 * CODE_W;
    localparam int CNT_W = $clog2(ACC_W + 1);

`ifdef JPEG_BYTE_STUFF_EN
    typedef enum logic [1:0] {RUN, STUFF, FLUSH} state_t;
`else
    typedef enum logic [1:0] {RUN, FLUSH} state_t;
`endif

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flushPend_q, flushPend_d;
    logic [7:0]         obyte_q, obyte_d;
    logic               ovalid_q, ovalid_d;
    logic               olast_q, olast_d;
    logic               rdyEn_q;

    logic               outFree, accept, load, loadLast;
    logic [7:0]         loadByte;
    logic [ACC_W-1:0]   accBase, codeMasked, appended, padMask;
    logic [CNT_W-1:0]   cntBase, cntAfter, padCnt;

    // rdyEn_q delays in_ready until the first clock edge after reset is released.
    assign in_ready   = rdyEn_q && (state_q == RUN) && (cnt_q <= CNT_W'(CODE_W)) && !rst;
    assign out_valid  = ovalid_q;
    assign out_byte   = obyte_q;
    assign out_last   = olast_q;
    assign flush_done = ((state_q == FLUSH) && (cnt_q == '0)) || (ovalid_q && olast_q && out_ready);

    always_comb begin
        state_d     = state_q;
        flushPend_d = flushPend_q;
        obyte_d     = obyte_q;
        ovalid_d    = ovalid_q;
        olast_d     = olast_q;
        load        = 1'b0;
        loadLast    = 1'b0;
        loadByte    = 8'h00;
        accBase     = acc_q;
        cntBase     = cnt_q;
        outFree     = !ovalid_q || out_ready;
        accept      = in_valid && in_ready;

        case (state_q)
            RUN, FLUSH: begin
                if ((cnt_q >= CNT_W'(8)) && outFree) begin
                    load     = 1'b1;
                    loadByte = acc_q[ACC_W-1 -: 8];
                    accBase  = acc_q << 8;
                    cntBase  = cnt_q - CNT_W'(8);
`ifdef JPEG_BYTE_STUFF_EN
                    if (loadByte == 8'hFF) begin
                        state_d = STUFF;
                    end else
`endif
                    if ((state_q == FLUSH) && (cnt_q == CNT_W'(8))) begin
                        loadLast    = 1'b1;
                        state_d     = RUN;
                        flushPend_d = 1'b0;
                    end
                end else if ((state_q == FLUSH) && (cnt_q == '0)) begin
                    state_d     = RUN;
                    flushPend_d = 1'b0;
                end
            end
`ifdef JPEG_BYTE_STUFF_EN
            // The stuffed zero is last when a flush has nothing left behind it.
            STUFF: begin
                if (outFree) begin
                    load     = 1'b1;
                    loadByte = 8'h00;
                    loadLast = flushPend_q && (cnt_q == '0);
                    if (loadLast) begin
                        state_d     = RUN;
                        flushPend_d = 1'b0;
                    end else begin
                        state_d = flushPend_q ? FLUSH : RUN;
                    end
                end
            end
`endif
            default: state_d = RUN;
        endcase

        // New code lands directly below whatever bits survive this cycle's emission.
        cntAfter   = cntBase + CNT_W'(in_len);
        padCnt     = (cntAfter + CNT_W'(7)) & ~CNT_W'(7);
        codeMasked = ACC_W'(in_code) & ~({ACC_W{1'b1}} << in_len);
        appended   = accBase | (codeMasked << (CNT_W'(ACC_W) - cntAfter));
        padMask    = ({ACC_W{1'b1}} >> cntAfter) & ~({ACC_W{1'b1}} >> padCnt);
        acc_d      = accBase;
        cnt_d      = cntBase;
        if (accept) begin
            if (in_flush) begin
                acc_d       = appended | padMask;
                cnt_d       = padCnt;
                flushPend_d = 1'b1;
                if (state_d == RUN) begin
                    state_d = FLUSH;
                end
            end else begin
                acc_d = appended;
                cnt_d = cntAfter;
            end
        end

        if (load) begin
            ovalid_d = 1'b1;
            obyte_d  = loadByte;
            olast_d  = loadLast;
        end else if (out_ready) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            acc_q       <= '0;
            cnt_q       <= '0;
            flushPend_q <= 1'b0;
            obyte_q     <= 8'h00;
            ovalid_q    <= 1'b0;
            olast_q     <= 1'b0;
            rdyEn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            flushPend_q <= flushPend_d;
            obyte_q     <= obyte_d;
            ovalid_q    <= ovalid_d;
            olast_q     <= olast_d;
            rdyEn_q     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb_jpeg_bit_packer: directed checks of packing, stuffing, flush padding, backpressure and reset.
// Expected bytes follow JPEG_BYTE_STUFF_EN when the build defines it.
module tb_jpeg_bit_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic [4:0]  in_len;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        flush_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] gotBytes[$];
    logic       gotLast[$];
    int         gotCyc[$];
    int         cyc     = 0;
    int         fdCount = 0;
    int         fdCyc   = 0;

    jpeg_bit_packer #(.CODE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    // Records every byte handshake and flush_done pulse, sampled mid low phase.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (!rst && out_valid && out_ready) begin
            gotBytes.push_back(out_byte);
            gotLast.push_back(out_last);
            gotCyc.push_back(cyc);
        end
        if (flush_done) begin
            fdCount++;
            fdCyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one code from a negedge and returns at the negedge after it was accepted.
    task automatic applyStimulus(input logic [15:0] code, input logic [4:0] len, input logic flush);
        int waitCycles;
        in_valid   = 1'b1;
        in_code    = code;
        in_len     = len;
        in_flush   = flush;
        waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    initial begin
        int base;
        int fdBase;
        logic stableOk;
        logic [7:0] bpExp [6];
        bpExp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_len    = '0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_byte", {24'b0, out_byte}, 32'h00);
        checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("rst_flush_done", {31'b0, flush_done}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("rel_in_ready_high", {31'b0, in_ready}, 32'd1);

        // Two nibbles make one byte, visible one cycle after the second accept.
        base = gotBytes.size();
        applyStimulus(16'h000A, 5'd4, 1'b0);
        applyStimulus(16'h0005, 5'd4, 1'b0);
        checkOutput("a5_not_yet", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("a5_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("a5_byte", {24'b0, out_byte}, 32'hA5);
        checkOutput("a5_last", {31'b0, out_last}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("a5_count", gotBytes.size() - base, 32'd1);

        base = gotBytes.size();
        applyStimulus(16'hFF12, 5'd16, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("ff12_b0", {24'b0, gotBytes[base]}, 32'hFF);
`ifdef JPEG_BYTE_STUFF_EN
        checkOutput("ff12_count", gotBytes.size() - base, 32'd3);
        checkOutput("ff12_b1", {24'b0, gotBytes[base+1]}, 32'h00);
        checkOutput("ff12_b2", {24'b0, gotBytes[base+2]}, 32'h12);
        checkOutput("ff12_gap1", gotCyc[base+1] - gotCyc[base], 32'd1);
        checkOutput("ff12_gap2", gotCyc[base+2] - gotCyc[base+1], 32'd1);
`else
        checkOutput("ff12_count", gotBytes.size() - base, 32'd2);
        checkOutput("ff12_b1", {24'b0, gotBytes[base+1]}, 32'h12);
        checkOutput("ff12_gap1", gotCyc[base+1] - gotCyc[base], 32'd1);
`endif

        // 101 padded with ones gives 0xBF, the last byte of the scan.
        base   = gotBytes.size();
        fdBase = fdCount;
        applyStimulus(16'h0005, 5'd3, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("flush_count", gotBytes.size() - base, 32'd1);
        checkOutput("flush_byte", {24'b0, gotBytes[base]}, 32'hBF);
        checkOutput("flush_last", {31'b0, gotLast[base]}, 32'd1);
        checkOutput("flush_done_count", fdCount - fdBase, 32'd1);
        checkOutput("flush_done_cycle", fdCyc, gotCyc[base]);

        base   = gotBytes.size();
        fdBase = fdCount;
        applyStimulus(16'h00FF, 5'd8, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("ffflush_b0", {24'b0, gotBytes[base]}, 32'hFF);
`ifdef JPEG_BYTE_STUFF_EN
        checkOutput("ffflush_count", gotBytes.size() - base, 32'd2);
        checkOutput("ffflush_last0", {31'b0, gotLast[base]}, 32'd0);
        checkOutput("ffflush_b1", {24'b0, gotBytes[base+1]}, 32'h00);
        checkOutput("ffflush_last1", {31'b0, gotLast[base+1]}, 32'd1);
`else
        checkOutput("ffflush_count", gotBytes.size() - base, 32'd1);
        checkOutput("ffflush_last0", {31'b0, gotLast[base]}, 32'd1);
`endif
        checkOutput("ffflush_done", fdCount - fdBase, 32'd1);

        // A flush with no buffered bits emits nothing but still signals done.
        base   = gotBytes.size();
        fdBase = fdCount;
        applyStimulus(16'h001F, 5'd0, 1'b1);
        checkOutput("empty_flush_done", {31'b0, flush_done}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("empty_flush_bytes", gotBytes.size() - base, 32'd0);
        checkOutput("empty_flush_pulses", fdCount - fdBase, 32'd1);

        base      = gotBytes.size();
        out_ready = 1'b0;
        applyStimulus(16'h1234, 5'd16, 1'b0);
        applyStimulus(16'h5678, 5'd16, 1'b0);
        checkOutput("bp_full_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_hold_byte", {24'b0, out_byte}, 32'h12);
        stableOk = 1'b1;
        in_valid = 1'b1;
        in_code  = 16'h9ABC;
        in_len   = 5'd16;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_byte !== 8'h12 || out_valid !== 1'b1 || in_ready !== 1'b0) stableOk = 1'b0;
        end
        checkOutput("bp_stall_stable", {31'b0, stableOk}, 32'd1);
        out_ready = 1'b1;
        applyStimulus(16'h9ABC, 5'd16, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("bp_count", gotBytes.size() - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("bp_byte%0d", i), {24'b0, gotBytes[base+i]}, {24'b0, bpExp[i]});
        end

        // High garbage bits above in_len must be masked off.
        base = gotBytes.size();
        applyStimulus(16'hFFFF, 5'd4, 1'b0);
        applyStimulus(16'h0000, 5'd4, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("mask_count", gotBytes.size() - base, 32'd1);
        checkOutput("mask_byte", {24'b0, gotBytes[base]}, 32'hF0);
        base = gotBytes.size();
        applyStimulus(16'hABCD, 5'd0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("len0_count", gotBytes.size() - base, 32'd0);

        out_ready = 1'b0;
        applyStimulus(16'h005A, 5'd8, 1'b1);
        @(negedge clk);
        checkOutput("midflush_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("midflush_last", {31'b0, out_last}, 32'd1);
        checkOutput("midflush_byte", {24'b0, out_byte}, 32'h5A);
        out_ready = 1'b1;
        #1;
        checkOutput("midflush_done_hi", {31'b0, flush_done}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("arst_out_last", {31'b0, out_last}, 32'd0);
        checkOutput("arst_flush_done", {31'b0, flush_done}, 32'd0);
        checkOutput("arst_out_byte", {24'b0, out_byte}, 32'h00);
        checkOutput("arst_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        base = gotBytes.size();
        applyStimulus(16'h000C, 5'd4, 1'b0);
        applyStimulus(16'h0003, 5'd4, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("post_rst_count", gotBytes.size() - base, 32'd1);
        checkOutput("post_rst_byte", {24'b0, gotBytes[base]}, 32'hC3);
        checkOutput("post_rst_last", {31'b0, gotLast[base]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
